// File: rtl/uart_char_tx_pkg.sv
// Shared types and constants for the UCI character UART transmitter.
package uart_char_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam logic [7:0] NEW_LINE        = 8'h0A;
  localparam logic [7:0] CARRIAGE_RETURN = 8'h0D;

endpackage

// File: rtl/uart_char_tx_fifo.sv
// Synchronous FIFO with push/pop, full/empty and an explicit occupancy count.
module char_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       pop,
  output logic [Width-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == CountW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_char_tx.sv
// 8N1 UART transmitter fed by a character FIFO from the UCI handler.
// Optional UART_TX_CRLF_EN expands each popped LF into a CR, LF frame pair.
module uart_char_tx
  import uart_char_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [7:0]                      char_in,
  input  logic                            char_in_valid,
  output logic                            char_in_ready,
  output logic                            tx_out,
  output logic                            busy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_out
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam logic [BaudW-1:0] BaudReload = BaudW'(BAUD_DIV - 1);

  uart_state_e      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_done, load_next;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;

  char_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (char_in_valid),
    .push_data(char_in),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count_out)
  );

  assign char_in_ready = ~fifo_full;
  assign bit_done      = (baud_q == '0);

`ifdef UART_TX_CRLF_EN
  logic lf_pending_q, lf_pending_d;
`endif

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
`ifdef UART_TX_CRLF_EN
    lf_pending_d = lf_pending_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          load_next = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          baud_d    = BaudReload;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (bit_done) begin
          baud_d = BaudReload;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
`ifdef UART_TX_CRLF_EN
          if (lf_pending_q) begin
            lf_pending_d = 1'b0;
            shift_d      = NEW_LINE;
            state_d      = StStart;
            baud_d       = BaudReload;
          end else if (!fifo_empty) begin
            load_next = 1'b1;
          end else begin
            state_d = StIdle;
          end
`else
          if (!fifo_empty) begin
            load_next = 1'b1;
          end else begin
            state_d = StIdle;
          end
`endif
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
    endcase

    // Pop the head straight into the shifter and begin a fresh start bit.
    if (load_next) begin
      fifo_pop = 1'b1;
      state_d  = StStart;
      baud_d   = BaudReload;
      shift_d  = fifo_rdata;
`ifdef UART_TX_CRLF_EN
      if (fifo_rdata == NEW_LINE) begin
        shift_d      = CARRIAGE_RETURN;
        lf_pending_d = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
`ifdef UART_TX_CRLF_EN
    busy_d = (state_q != StIdle) | ~fifo_empty | lf_pending_q;
`else
    busy_d = (state_q != StIdle) | ~fifo_empty;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_CRLF_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      lf_pending_q <= 1'b0;
    end else begin
      lf_pending_q <= lf_pending_d;
    end
  end
`endif

  assign tx_out   = tx_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// Directed self-checking bench for uart_char_tx at BAUD_DIV=4, FIFO_DEPTH=4.
module tb_uart_char_tx;

  localparam int BaudDiv   = 4;
  localparam int FifoDepth = 4;
  localparam int Timeout   = 300;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_in_valid = 1'b0;
  logic       char_in_ready;
  logic       tx_out;
  logic       busy_out;
  logic [2:0] fifo_count_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] stream [16];
  logic [7:0] got [16];
  int         starts [16];
  bit         oks [16];
  int         ready_bad;
  bit         saw_full;

  uart_char_tx #(
    .BAUD_DIV  (BaudDiv),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .char_in       (char_in),
    .char_in_valid (char_in_valid),
    .char_in_ready (char_in_ready),
    .tx_out        (tx_out),
    .busy_out      (busy_out),
    .fifo_count_out(fifo_count_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Called at a negedge; returns at the negedge after the accepting edge (cyc = E).
  task automatic push_one(input logic [7:0] c, output int e);
    int t = 0;
    char_in = c;
    char_in_valid = 1'b1;
    while (!char_in_ready && t < Timeout) begin
      @(negedge clk_in);
      t++;
    end
    @(negedge clk_in);
    e = cyc;
    char_in_valid = 1'b0;
  endtask

  // Captures one frame sample-per-cycle; returns at the negedge of its last stop sample.
  task automatic recv_frame(output logic [7:0] data, output int start, output bit shape_ok);
    int t = 0;
    logic s [10*BaudDiv];
    data = 8'h00;
    start = -1;
    shape_ok = 1'b0;
    while (tx_out !== 1'b0 && t < Timeout) begin
      @(negedge clk_in);
      t++;
    end
    if (tx_out !== 1'b0) return;
    start = cyc;
    for (int k = 0; k < 10*BaudDiv; k++) begin
      s[k] = tx_out;
      if (k < 10*BaudDiv - 1) @(negedge clk_in);
    end
    shape_ok = (s[0] === 1'b0) && (s[9*BaudDiv] === 1'b1);
    for (int b = 0; b < 10; b++)
      for (int j = 1; j < BaudDiv; j++)
        if (s[b*BaudDiv+j] !== s[b*BaudDiv]) shape_ok = 1'b0;
    for (int b = 0; b < 8; b++) data[b] = s[(b+1)*BaudDiv];
  endtask

  task automatic push_stream(input int n);
    int i = 0;
    int t = 0;
    logic took;
    ready_bad = 0;
    saw_full = 1'b0;
    char_in = stream[0];
    char_in_valid = 1'b1;
    while (i < n && t < 2000) begin
      took = char_in_ready;
      if (fifo_count_out == 3'(FifoDepth)) begin
        saw_full = 1'b1;
        if (char_in_ready !== 1'b0) ready_bad++;
      end
      @(negedge clk_in);
      t++;
      if (took) begin
        i++;
        if (i < n) char_in = stream[i];
      end
    end
    char_in_valid = 1'b0;
  endtask

  task automatic recv_stream(input int n);
    for (int k = 0; k < n; k++) recv_frame(got[k], starts[k], oks[k]);
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    char_in = 8'h55;
    char_in_valid = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_out); end
    checks++; if (char_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", char_in_ready); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
    checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count_out); end
    rst_in = 1'b1;
    char_in_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL reset_nothing_taken got %0d want 0", fifo_count_out); end
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_idle_tx got %b want 1", tx_out); end
  endtask

  task automatic test_single;
    int e, st;
    logic [7:0] d;
    bit ok;
    push_one(8'h62, e);
    checks++; if (fifo_count_out !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", fifo_count_out); end
    recv_frame(d, st, ok);
    checks++; if (st !== e + 2) begin errors++; $display("FAIL single_start got %0d want %0d", st, e + 2); end
    checks++; if (d !== 8'h62) begin errors++; $display("FAIL single_data got %h want 62", d); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_shape got %b want 1", ok); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_end got %b want 1", busy_out); end
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0 at cycle %0d", busy_out, cyc - e); end
  endtask

  task automatic test_backpressure;
    logic [7:0] s [7] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    for (int k = 0; k < 7; k++) stream[k] = s[k];
    fork
      push_stream(7);
      recv_stream(7);
    join
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_reached_full got %b want 1", saw_full); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL bp_ready_when_full got %0d want 0", ready_bad); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== s[k] || oks[k] !== 1'b1)
        begin errors++; $display("FAIL bp_byte%0d got %h/%b want %h/1", k, got[k], oks[k], s[k]); end
    end
    for (int k = 1; k < 7; k++) begin
      checks++;
      if (starts[k] !== starts[0] + 10*BaudDiv*k)
        begin errors++; $display("FAIL bp_gap%0d got %0d want %0d", k, starts[k], starts[0] + 10*BaudDiv*k); end
    end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL bp_busy_last got %b want 1", busy_out); end
    @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0 || cyc - starts[0] !== 280)
      begin errors++; $display("FAIL bp_total got busy %b at %0d want 0 at 280", busy_out, cyc - starts[0]); end
  endtask

  task automatic test_crlf;
    int e, st1, st2;
    logic [7:0] d1, d2;
    bit ok1, ok2;
    push_one(8'h0A, e);
    recv_frame(d1, st1, ok1);
`ifdef UART_TX_CRLF_EN
    checks++; if (d1 !== 8'h0D || ok1 !== 1'b1) begin errors++; $display("FAIL crlf_cr got %h/%b want 0d/1", d1, ok1); end
    recv_frame(d2, st2, ok2);
    checks++; if (d2 !== 8'h0A || ok2 !== 1'b1) begin errors++; $display("FAIL crlf_lf got %h/%b want 0a/1", d2, ok2); end
    checks++; if (st2 !== st1 + 10*BaudDiv) begin errors++; $display("FAIL crlf_gap got %0d want %0d", st2, st1 + 10*BaudDiv); end
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || cyc - st1 !== 80) begin errors++; $display("FAIL crlf_len got busy %b at %0d want 0 at 80", busy_out, cyc - st1); end
`else
    checks++; if (d1 !== 8'h0A || ok1 !== 1'b1) begin errors++; $display("FAIL lf_frame got %h/%b want 0a/1", d1, ok1); end
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || cyc - st1 !== 40) begin errors++; $display("FAIL lf_len got busy %b at %0d want 0 at 40", busy_out, cyc - st1); end
    d2 = 8'h00; st2 = 0; ok2 = 1'b0;
`endif
    checks++; if (st1 !== e + 2) begin errors++; $display("FAIL crlf_start got %0d want %0d", st1, e + 2); end
  endtask

  task automatic test_reset_mid_frame;
    int e1, e2, e3, st, lows;
    logic [7:0] d;
    bit ok;
    push_one(8'h78, e1);
    push_one(8'h79, e2);
    // Middle of data bit 3 on the line: start at e1+2, bit 3 begins 16 cycles later.
    while (cyc < e1 + 2 + 4*BaudDiv + 1) @(negedge clk_in);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL mid_bit3 got %b want 1", tx_out); end
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL mid_tx got %b want 1", tx_out); end
    checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy_out); end
    rst_in = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL mid_no_resume got %0d low cycles want 0", lows); end
    push_one(8'h41, e3);
    recv_frame(d, st, ok);
    checks++; if (d !== 8'h41 || ok !== 1'b1) begin errors++; $display("FAIL mid_after got %h/%b want 41/1", d, ok); end
    checks++; if (st !== e3 + 2) begin errors++; $display("FAIL mid_after_start got %0d want %0d", st, e3 + 2); end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 3*FifoDepth; k++) stream[k] = 8'h30 + 8'(k);
    fork
      push_stream(3*FifoDepth);
      recv_stream(3*FifoDepth);
    join
    for (int k = 0; k < 3*FifoDepth; k++) begin
      checks++;
      if (got[k] !== 8'h30 + 8'(k) || oks[k] !== 1'b1)
        begin errors++; $display("FAIL wrap_byte%0d got %h/%b want %h/1", k, got[k], oks[k], 8'h30 + 8'(k)); end
    end
    @(negedge clk_in);
    checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", fifo_count_out); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_crlf;
    test_reset_mid_frame;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_char_tx.md
# uart_char_tx

Serialises the UCI handler's outgoing character stream onto the host UART TX line. It is the stage directly downstream of the UCI handler and consumes its `char_out` / `char_out_valid` / `char_out_ready` handshake. A small synchronous FIFO absorbs bursts such as `info` and `bestmove` lines. The FSM then emits 8N1 frames, LSB first, back-to-back at a fixed clocks-per-bit divisor.

## Interface
- Clocking (already decided): one clock; reset is synchronous and active-low.
- `BAUD_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: character FIFO entries. Must be a power of 2 and ≥ 2.
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  synchronous, active-low reset.
- `char_in`  input  8  character from the UCI handler (`char_out`).
- `char_in_valid`  input  1  `char_in` valid.
- `char_in_ready`  output  1  FIFO can accept a character this cycle.
- `tx_out`  output  1  UART line. Idles high.
- `busy_out`  output  1  FSM not IDLE, or FIFO non-empty.
- `fifo_count_out`  output  $clog2(FIFO_DEPTH+1)  characters currently queued.

## Operation
- Push: a character is written on any edge where `char_in_valid && char_in_ready`.
- `char_in_ready = (count != FIFO_DEPTH)`. It is derived from the registered count only. A pop in the same cycle does not raise ready.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. The head is popped and loaded into the shift register.
  - START: line low for one bit time → DATA.
  - DATA: 8 bits, LSB first. Shift right each bit time. A 3-bit bit index counts 0..7. Bit 7 done → STOP.
  - STOP: line high for one bit time. At the end of STOP: if the FIFO is non-empty (or a CRLF LF is pending), pop/load and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: loads `BAUD_DIV-1` on entry to each bit and counts down. The bit ends at 0, so each bit lasts exactly `BAUD_DIV` cycles and a frame lasts `10*BAUD_DIV`.
- Simultaneous push and pop: both take effect and the count is unchanged. A push into an empty FIFO cannot pop in the same cycle.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is tracked separately, so full and empty are unambiguous.
- Reset values: `tx_out=1`, `char_in_ready=1`, `busy_out=0`, `fifo_count_out=0`, FSM=IDLE, baud counter=0, pointers=0, CRLF pending flag=0.
- Reset mid-frame:
  - The frame is truncated and `tx_out` is 1 after the reset edge.
  - The FIFO contents are discarded.
  - No partial resume occurs.

## Timing
- Push accepted at edge E into an empty idle block:
  - Pop at edge E+1.
  - `tx_out` low from E+2 for `BAUD_DIV` cycles.
- `tx_out`, `busy_out` and `fifo_count_out` are registered. `char_in_ready` is combinational from the registered count.
- Sustained throughput: one character per `10*BAUD_DIV` cycles. The stop bit is immediately followed by the next start bit.
- Holding `char_in_valid` while not ready is legal. The character is taken on the first ready edge.

## Configuration
- `UART_TX_CRLF_EN` defined:
  - A popped 0x0A is transmitted as frame 0x0D followed by frame 0x0A.
  - A pending-LF flag forces the second frame without a second pop.
  - A newline therefore costs `20*BAUD_DIV` cycles.
  - `busy_out` stays high while the flag is set.
- Undefined: bytes are transmitted verbatim, and the pending flag and its logic are absent.

## Structure
- The shared types package holds:
  - UART FSM enum (IDLE, START, DATA, STOP).
  - Constants `NEW_LINE` = 8'h0A and `CARRIAGE_RETURN` = 8'h0D.
- Sub-module `char_fifo` is a synchronous FIFO parameterised by width/depth, with push/pop, full/empty and count. The FSM and baud counter stay in `uart_char_tx`.

## Test plan
- Reset: hold `rst_in`=0 for 2 cycles with `char_in_valid`=1 → `tx_out`=1, `char_in_ready`=1, `busy_out`=0, count=0, nothing accepted.
- Single byte, `BAUD_DIV`=4, push 0x62 → `tx_out` bit sequence 0,0,1,0,0,0,1,1,0,1, each held 4 cycles, first low at E+2. `busy_out` falls after 40 cycles.
- Backpressure, `FIFO_DEPTH`=4, `BAUD_DIV`=4: push "abcdefg" with valid held continuously →
  - `char_in_ready` drops once count=4.
  - All 7 bytes appear on the line in order.
  - Each stop bit is followed directly by a start bit.
  - Total time 280 cycles from the first start bit.
- CRLF with macro: push 0x0A → frames 0x0D then 0x0A, 80 cycles at `BAUD_DIV`=4. Without macro: a single 0x0A frame, 40 cycles.
- Reset mid-frame: push "xy", assert reset during DATA bit 3 →
  - `tx_out`=1 next cycle, count=0.
  - "y" is never sent.
  - A later push of 0x41 transmits correctly.
- Wrap-around: push and drain 3×`FIFO_DEPTH` bytes with incrementing values → line data matches the push order exactly and count returns to 0.
